// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one fixed-latency pipelined fp32 adder among NREQ requesters,
// with a tag pipeline that routes each result back to the requester that issued it.
module fp_add_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CW   = $clog2(LAT + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0][31:0]  req_a,
    input  logic [NREQ-1:0][31:0]  req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   add_valid,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_result,
    output logic [NREQ-1:0]        resp_valid,
    output logic [31:0]            resp_data,
    output logic [CW-1:0]          inflight
);
    logic [IDW-1:0] ptr, win, issue_id;
    logic           found, hs;
    logic [LAT-1:0] tv;
    logic [IDW-1:0] tid [LAT];

    // first valid requester scanning upward from the one after the last winner
    always_comb begin
        found = 1'b0;
        win = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                win = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign hs = found && !rst;
    assign req_ready = hs ? NREQ'(1) << win : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
            add_valid <= 1'b0;
            add_a <= '0;
            add_b <= '0;
            issue_id <= '0;
            tv <= '0;
            inflight <= '0;
        end else begin
            add_valid <= hs;
            if (hs) begin
                ptr <= win;
                add_a <= req_a[win];
                add_b <= req_b[win];
                issue_id <= win;
            end
            tv[0] <= add_valid;
            for (int k = 1; k < LAT; k++)
                tv[k] <= tv[k-1];
            inflight <= inflight + CW'(hs) - CW'(tv[LAT-1]);
        end
    end

    always_ff @(posedge clk) begin
        tid[0] <= issue_id;
        for (int k = 1; k < LAT; k++)
            tid[k] <= tid[k-1];
    end

    // results still in the adder when reset hits must never surface as responses
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            resp_valid[i] = !rst && tv[LAT-1] && tid[LAT-1] == IDW'(i);
    end

    assign resp_data = add_result;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed and random stimulus against a queue-based model of grants,
// issue order and response timing, with an fp32 adder model built on real arithmetic.
module tb_fp_add_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int CW   = $clog2(LAT + 2);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready, resp_valid;
    logic [NREQ-1:0][31:0] req_a, req_b;
    logic                  add_valid;
    logic [31:0]           add_a, add_b, add_result, resp_data;
    logic [CW-1:0]         inflight;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .resp_valid(resp_valid), .resp_data(resp_data),
        .inflight(inflight)
    );

    function automatic real f2r(logic [31:0] f);
        if (f[30:23] == 8'd0) return 0.0;
        return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [24:0] m;
        logic [28:0] rem;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    // operands in a narrow exponent band so the double sum is exact before rounding to single
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    logic [31:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_result = apipe[LAT-1];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] sum;
        longint      due;
    } rsp_t;

    rsp_t            q[$];
    int              mptr = NREQ - 1;
    logic            exp_av = 1'b0;
    logic [31:0]     exp_a = '0, exp_b = '0;

    initial forever begin
        int w;
        logic [NREQ-1:0] er, ev;
        @(negedge clk);
        if (cyc > 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            er = (rst || w < 0) ? '0 : NREQ'(1) << w;
            chk("ready", 32'(req_ready), 32'(er));
            chk("add_valid", 32'(add_valid), 32'(exp_av));
            chk("add_a", add_a, exp_a);
            chk("add_b", add_b, exp_b);
            ev = '0;
            if (q.size() > 0 && q[0].due == cyc && !rst) ev = NREQ'(1) << q[0].id;
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            if (ev != '0) chk("resp_data", resp_data, q[0].sum);
            chk("inflight", 32'(inflight), 32'(q.size()));
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (rst) begin
                q.delete();
                mptr = NREQ - 1;
                exp_av = 1'b0;
                exp_a = '0;
                exp_b = '0;
            end else if (w >= 0) begin
                mptr = w;
                q.push_back('{w, fadd(req_a[w], req_b[w]), cyc + 1 + LAT});
                exp_av = 1'b1;
                exp_a = req_a[w];
                exp_b = req_b[w];
            end else begin
                exp_av = 1'b0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (LAT + 3) tick();
    endtask

    initial begin
        int cnt [NREQ];
        int hs, peak, first_hs, first_rsp, rises, av, r0, r1;
        logic [NREQ-1:0] g;
        logic prev;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_add_valid", 32'(add_valid), 32'd0);
        chk("reset_add_a", add_a, 32'd0);
        chk("reset_inflight", 32'(inflight), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        tick();

        // single op 1.2 + 1.4
        req_valid = 4'b0001;
        req_a[0] = 32'h3f99999a;
        req_b[0] = 32'h3fb33333;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_add_valid", 32'(add_valid), 32'd1);
        chk("t1_add_a", add_a, 32'h3f99999a);
        chk("t1_add_b", add_b, 32'h3fb33333);
        chk("t1_inflight1", 32'(inflight), 32'd1);
        for (int k = 2; k <= LAT; k++) begin
            @(negedge clk);
            chk("t1_no_resp", 32'(resp_valid), 32'd0);
            chk("t1_inflight", 32'(inflight), 32'd1);
        end
        @(negedge clk);
        chk("t1_resp_valid", 32'(resp_valid), 32'd1);
        chk("t1_resp_data", resp_data, 32'h40266666);
        chk("t1_inflight_last", 32'(inflight), 32'd1);
        @(negedge clk);
        chk("t1_inflight_done", 32'(inflight), 32'd0);
        chk("t1_resp_done", 32'(resp_valid), 32'd0);
        tick();

        // round-robin fairness, four requesters continuously valid
        do_reset();
        req_a[0] = 32'h3f800000; req_b[0] = 32'h40000000;
        req_a[1] = 32'h40400000; req_b[1] = 32'h40800000;
        req_a[2] = 32'h3fc00000; req_b[2] = 32'h40100000;
        req_a[3] = 32'h3f000000; req_b[3] = 32'h3e800000;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k < 8) chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (resp_valid[2]) chk("t2_resp2_data", resp_data, 32'h40700000);
            for (int i = 0; i < NREQ; i++) cnt[i] += int'(resp_valid[i]);
            tick();
            if (k == 7) req_valid = '0;
        end
        for (int i = 0; i < NREQ; i++) chk("t2_pulses", 32'(cnt[i]), 32'd2);

        // pointer rotation with requesters 1 and 3 only
        do_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_grant", 32'(req_ready), (k % 2) ? 32'd8 : 32'd2);
            tick();
        end
        drain();

        // single requester back-to-back
        req_valid = 4'b0100;
        req_a[2] = rnd_f();
        req_b[2] = rnd_f();
        hs = 0; peak = 0; first_hs = -1; first_rsp = -1; rises = 0; r0 = 0; prev = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_valid[2] && req_ready[2]) begin
                hs++;
                if (first_hs < 0) first_hs = k;
            end
            if (resp_valid[2]) begin
                r0++;
                if (first_rsp < 0) first_rsp = k;
                if (!prev) rises++;
            end
            prev = resp_valid[2];
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
            req_a[2] = rnd_f();
            req_b[2] = rnd_f();
            if (k == 9) req_valid = '0;
        end
        chk("t4_handshakes", 32'(hs), 32'd10);
        chk("t4_pulses", 32'(r0), 32'd10);
        chk("t4_pulse_runs", 32'(rises), 32'd1);
        chk("t4_latency", 32'(first_rsp - first_hs), 32'(LAT + 1));
        chk("t4_peak_inflight", 32'(peak), 32'(LAT + 1));
        drain();

        // reset while three ops are in flight
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = '0;
        repeat (2) tick();
        do_reset();
        r0 = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            r0 += int'(resp_valid != '0);
            tick();
        end
        chk("t5_no_resp", 32'(r0), 32'd0);
        @(negedge clk);
        chk("t5_inflight", 32'(inflight), 32'd0);
        tick();
        req_valid = 4'b1011;
        @(negedge clk);
        chk("t5_first_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        drain();

        // cancelled request from requester 1
        do_reset();
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t6_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        av = 0; r0 = 0; r1 = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            av += int'(add_valid);
            r0 += int'(resp_valid[0]);
            r1 += int'(resp_valid[1]);
            tick();
        end
        chk("t6_issues", 32'(av), 32'd1);
        chk("t6_resp0", 32'(r0), 32'd1);
        chk("t6_resp1", 32'(r1), 32'd0);

        // random traffic with held operands, cancellations and occasional reset
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            tick();
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !g[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) != 0);
                end else begin
                    req_valid[i] = 1'($urandom);
                    req_a[i] = rnd_f();
                    req_b[i] = rnd_f();
                end
            end
        end
        rst = 1'b0;
        drain();
        @(negedge clk);
        chk("final_inflight", 32'(inflight), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
